// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_TAG_W   = 3;
  localparam int CDB_DATA_W  = 32;

  // One result as presented by an ALU and as broadcast on the CDB.
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_req_t;

  // Rotating-priority pointer value after producer w has been granted.
  function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
    return (w + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational rotating-priority picker: searches req starting at ptr and
// returns a one-hot grant plus the winning index.
module cdb_arbiter_rr
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PW-1:0]      win_o,
  output logic               any_o
);

  // First set request at or after ptr (wrapping) wins.
  always_comb begin
    grant_o = '0;
    win_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int unsigned j;
      j = (32'(k) + 32'(ptr_i)) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        win_o      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per ALU, round-robin broadcast of one
// registered {tag, data} per cycle, and a one-hot ROB strobe.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [DATA_W-1:0]              cdb_data,
  output logic [(2**TAG_W)-1:0]          rob_set_valid
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_valid_q;
  logic [TAG_W-1:0]   buf_tag_q  [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               cdb_valid_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [DATA_W-1:0]  cdb_data_q;

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      win;
  logic               any_grant;

  cdb_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .req_i   (buf_valid_q),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .win_o   (win),
    .any_o   (any_grant)
  );

  // A granted buffer drains this edge, so it can take a new result at once.
  // Flush deliberately does not gate ready; it only blocks the capture.
  always_comb begin
    req_ready = ~buf_valid_q | grant;
    ptr_d     = any_grant ? PW'(rr_next(32'(win), NUM_REQ)) : ptr_q;
  end

  // Buffers, rotating pointer and broadcast registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else if (flush) begin
      buf_valid_q <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          buf_valid_q[i] <= 1'b1;
          buf_tag_q[i]   <= req_tag[i];
          buf_data_q[i]  <= req_data[i];
        end else if (grant[i]) begin
          buf_valid_q[i] <= 1'b0;
        end
      end
      ptr_q       <= ptr_d;
      cdb_valid_q <= any_grant;
      if (any_grant) begin
        cdb_tag_q  <= buf_tag_q[win];
        cdb_data_q <= buf_data_q[win];
      end
    end
  end

  // ROB strobe follows the broadcast registers directly.
  always_comb begin
    rob_set_valid = '0;
    if (cdb_valid_q) rob_set_valid[cdb_tag_q] = 1'b1;
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][2:0]  req_tag;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic             cdb_valid;
  logic [2:0]       cdb_tag;
  logic [31:0]      cdb_data;
  logic [7:0]       rob_set_valid;

  int n_chk  = 0;
  int n_pass = 0;

  cdb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_tag       (req_tag),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .rob_set_valid (rob_set_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic expect_bcast(input string tag, input logic [2:0] t, input logic [31:0] d);
    chk({tag, "_v"}, cdb_valid, 1'b1);
    chk({tag, "_tag"}, cdb_tag, t);
    chk({tag, "_data"}, cdb_data, d);
    chk({tag, "_rob"}, rob_set_valid, 8'h01 << t);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_v"}, cdb_valid, 1'b0);
    chk({tag, "_rob"}, rob_set_valid, 8'h00);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // 1. reset
    step();
    chk("rst_ready", req_ready, 4'b1111);
    expect_idle("rst");
    chk("rst_tag", cdb_tag, 3'd0);
    chk("rst_data", cdb_data, 32'd0);
    step();
    rst = 1'b0;

    // 2. single result from producer 2
    req_valid   = 4'b0100;
    req_tag[2]  = 3'd5;
    req_data[2] = 32'hDEADBEEF;
    step();
    idle_inputs();
    expect_idle("single_lat");
    step();
    expect_bcast("single", 3'd5, 32'hDEADBEEF);
    step();
    expect_idle("single_after");
    chk("single_tag_hold", cdb_tag, 3'd5);

    // 3. contention, also reset clears held broadcast tag/data
    do_reset();
    chk("rst2_tag", cdb_tag, 3'd0);
    chk("rst2_data", cdb_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      req_tag[i]  = 3'(i);
      req_data[i] = 32'h10 + 32'(i);
    end
    req_valid = 4'b1111;
    step();
    idle_inputs();
    chk("cont_ready0", req_ready, 4'b0001);
    expect_idle("cont_lat");
    step();
    expect_bcast("cont0", 3'd0, 32'h10);
    chk("cont_ready1", req_ready, 4'b0011);
    step();
    expect_bcast("cont1", 3'd1, 32'h11);
    chk("cont_ready2", req_ready, 4'b0111);
    step();
    expect_bcast("cont2", 3'd2, 32'h12);
    chk("cont_ready3", req_ready, 4'b1111);
    step();
    expect_bcast("cont3", 3'd3, 32'h13);
    step();
    expect_idle("cont_end");

    // 4. rotation after a grant to producer 2
    do_reset();
    req_valid   = 4'b0100;
    req_tag[2]  = 3'd5;
    req_data[2] = 32'h22;
    step();
    idle_inputs();
    step();
    expect_bcast("rot_p2", 3'd5, 32'h22);
    req_valid   = 4'b1001;
    req_tag[0]  = 3'd1;
    req_data[0] = 32'hA0;
    req_tag[3]  = 3'd6;
    req_data[3] = 32'hA3;
    step();
    idle_inputs();
    expect_idle("rot_lat");
    step();
    expect_bcast("rot_p3", 3'd6, 32'hA3);
    step();
    expect_bcast("rot_p0", 3'd1, 32'hA0);
    step();
    expect_idle("rot_end");

    // 5. backpressure on producer 1 while producer 0 holds priority
    do_reset();
    req_valid   = 4'b0011;
    req_tag[0]  = 3'd7;
    req_data[0] = 32'h70;
    req_tag[1]  = 3'd4;
    req_data[1] = 32'h41;
    step();
    req_valid   = 4'b0010;
    req_tag[0]  = 3'd0;
    req_data[0] = 32'h0;
    req_tag[1]  = 3'd6;
    req_data[1] = 32'h61;
    chk("bp_ready_blocked", req_ready, 4'b1101);
    step();
    expect_bcast("bp_t7", 3'd7, 32'h70);
    chk("bp_ready_refill", req_ready, 4'b1111);
    step();
    idle_inputs();
    expect_bcast("bp_t4", 3'd4, 32'h41);
    step();
    expect_bcast("bp_t6", 3'd6, 32'h61);
    step();
    expect_idle("bp_end");

    // 6. flush with three buffers valid and a fresh offer on producer 3
    do_reset();
    req_valid   = 4'b0100;
    req_tag[2]  = 3'd3;
    req_data[2] = 32'h53;
    step();
    idle_inputs();
    step();
    expect_bcast("fl_pre", 3'd3, 32'h53);
    req_valid = 4'b0111;
    req_tag[0] = 3'd1; req_data[0] = 32'hB0;
    req_tag[1] = 3'd4; req_data[1] = 32'hB1;
    req_tag[2] = 3'd5; req_data[2] = 32'hB2;
    step();
    idle_inputs();
    flush       = 1'b1;
    req_valid   = 4'b1000;
    req_tag[3]  = 3'd2;
    req_data[3] = 32'hBB;
    chk("fl_ready", req_ready, 4'b1001);
    step();
    idle_inputs();
    expect_idle("fl_c0");
    step();
    expect_idle("fl_c1");
    step();
    expect_idle("fl_c2");
    req_valid   = 4'b1001;
    req_tag[0]  = 3'd0;
    req_data[0] = 32'hC0;
    req_tag[3]  = 3'd7;
    req_data[3] = 32'hC3;
    step();
    idle_inputs();
    expect_idle("fl_c3");
    step();
    expect_bcast("fl_ptr0", 3'd0, 32'hC0);
    step();
    expect_bcast("fl_ptr3", 3'd7, 32'hC3);
    step();
    expect_idle("fl_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
